muldiv_unit: RTL



---
 rtl/muldiv_unit.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// RV32M iterative multiply/divide sequencer; stalls execute until its result is ready.
// Latency: N+1 cycles from start (N = XLEN/BITS_PER_CYCLE); 1 cycle for trivial ops when MULDIV_EARLY_OUT_EN is defined.
// Backpressure: stall high while busy; result and done held in DONE while hold is high.
module muldiv_unit #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            hold,
    input  logic            invalidate,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int N     = XLEN / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        op_q;
    logic              neg_a_q, neg_b_q, bzero_q;
    logic [XLEN-1:0]   hi_q, lo_q, opnd_q;
    logic              done_q;
    logic [XLEN-1:0]   result_q;

    logic              sgn_a, sgn_b, neg_a, neg_b;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN-1:0]   hi_d, lo_d;
    logic [XLEN:0]     sum, shifted;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   fix_res;

    // MUL keeps only the low half, so its signedness choice is immaterial.
    assign sgn_a = op[2] ? !op[0] : (op[1:0] != 2'b11);
    assign sgn_b = op[2] ? !op[0] : !op[1];
    assign neg_a = sgn_a & rs1_data[XLEN-1];
    assign neg_b = sgn_b & rs2_data[XLEN-1];
    assign a_mag = neg_a ? -rs1_data : rs1_data;
    assign b_mag = neg_b ? -rs2_data : rs2_data;

    // hi/lo hold {partial product, multiplier} or {remainder, dividend->quotient}.
    always_comb begin
        hi_d    = hi_q;
        lo_d    = lo_q;
        sum     = '0;
        shifted = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (op_q[2]) begin
                shifted = {hi_d, lo_d[XLEN-1]};
                lo_d    = {lo_d[XLEN-2:0], 1'b0};
                if (shifted >= {1'b0, opnd_q}) begin
                    shifted = shifted - {1'b0, opnd_q};
                    lo_d[0] = 1'b1;
                end
                hi_d = shifted[XLEN-1:0];
            end else begin
                sum  = {1'b0, hi_d} + (lo_d[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
                lo_d = {sum[0], lo_d[XLEN-1:1]};
                hi_d = sum[XLEN:1];
            end
        end
    end

    always_comb begin
        prod = {hi_d, lo_d};
        if (neg_a_q ^ neg_b_q)
            prod = -prod;
        fix_res = '0;
        if (!op_q[2])
            fix_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        else if (op_q[1])
            fix_res = neg_a_q ? -hi_d : hi_d;
        else if (bzero_q)
            fix_res = '1;
        else
            fix_res = (neg_a_q ^ neg_b_q) ? -lo_d : lo_d;
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic            div_zero, div_ovf, mul_zero, early_vld;
    logic [XLEN-1:0] early_res;

    assign div_zero  = op[2] && (rs2_data == '0);
    assign div_ovf   = op[2] && !op[0] && (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
    assign mul_zero  = !op[2] && ((rs1_data == '0) || (rs2_data == '0));
    assign early_vld = div_zero || div_ovf || mul_zero;

    always_comb begin
        early_res = '0;
        if (div_zero)
            early_res = op[1] ? rs1_data : '1;
        else if (div_ovf)
            early_res = op[1] ? '0 : rs1_data;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            bzero_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else if (invalidate) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        neg_a_q <= neg_a;
                        neg_b_q <= neg_b;
                        bzero_q <= (rs2_data == '0);
                        hi_q    <= '0;
                        lo_q    <= op[2] ? a_mag : b_mag;
                        opnd_q  <= op[2] ? b_mag : a_mag;
`ifdef MULDIV_EARLY_OUT_EN
                        if (early_vld) begin
                            state_q  <= S_DONE;
                            done_q   <= 1'b1;
                            result_q <= early_res;
                        end else begin
                            state_q <= S_BUSY;
                            cnt_q   <= CNT_W'(N);
                        end
`else
                        state_q <= S_BUSY;
                        cnt_q   <= CNT_W'(N);
`endif
                    end
                end
                S_BUSY: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        result_q <= fix_res;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    // start is ignored here: it still belongs to the op being captured.
                    if (!hold) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign stall  = ((state_q == S_IDLE) && start) || (state_q == S_BUSY);
    assign done   = done_q;
    assign result = result_q;

endmodule
